// File: rtl/operand_reg_file.sv
// operand_reg_file: per-warp scalar register file with two operand read ports.
// Storage is split into NUM_BANKS banks; bank = (addr + warp_id) mod NUM_BANKS.
// Two same-cycle reads hitting one bank (different regs) are serialized: port 1
// answers at T+1, port 2 at T+2, with busy high during T+1.
// Optional feature macro: RF_WRITE_BYPASS_EN forwards a same-cycle matching
// write to the read result; without it a read returns the pre-write value.
module operand_reg_file #(
    parameter int NUM_WARPS = 32,
    parameter int NUM_REGS  = 32,
    parameter int DATA_W    = 32,
    parameter int NUM_BANKS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(NUM_WARPS)-1:0] reg_file_read_warp_id,
    input  logic                         oprand_1_request,
    input  logic [$clog2(NUM_REGS)-1:0]  oprand_1_addr,
    output logic                         oprand_1_data_valid,
    output logic [DATA_W-1:0]            oprand_1_data,
    input  logic                         oprand_2_request,
    input  logic [$clog2(NUM_REGS)-1:0]  oprand_2_addr,
    output logic                         oprand_2_data_valid,
    output logic [DATA_W-1:0]            oprand_2_data,
    output logic                         busy,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_WARPS)-1:0] wr_warp_id,
    input  logic [$clog2(NUM_REGS)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         err
);
    localparam int WW    = $clog2(NUM_WARPS);
    localparam int AW    = $clog2(NUM_REGS);
    localparam int BB    = $clog2(NUM_BANKS);
    // Within a bank, a warp's registers are distinguished by the addr bits above
    // the bank-select bits, so {warp, addr[AW-1:BB]} is a unique entry index.
    localparam int IW    = WW + AW - BB;
    localparam int DEPTH = 2 ** IW;

    typedef enum logic [0:0] {IDLE, SECOND} state_t;

    state_t            state;
    logic [WW-1:0]     p2_warp;
    logic [AW-1:0]     p2_addr;
    logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

    function automatic logic [BB-1:0] bank_of(input logic [WW-1:0] w, input logic [AW-1:0] a);
        logic [AW-1:0] s;
        s = a + AW'(w);
        return s[BB-1:0];
    endfunction

    function automatic logic warp_ok(input logic [WW-1:0] w);
        return 32'(w) < NUM_WARPS;
    endfunction

    // Read value for one warp/reg: reg 0 and out-of-range warps read as 0.
    function automatic logic [DATA_W-1:0] rd(input logic [WW-1:0] w, input logic [AW-1:0] a);
        logic [DATA_W-1:0] r;
        r = '0;
        if (a != '0 && warp_ok(w)) begin
            r = mem[bank_of(w, a)][{w, a[AW-1:BB]}];
`ifdef RF_WRITE_BYPASS_EN
            if (wr_en && wr_warp_id == w && wr_addr == a)
                r = wr_data;
`endif
        end
        return r;
    endfunction

    // Banked storage: one write per cycle, reg 0 and bad warps discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int i = 0; i < DEPTH; i++)
                    mem[b][i] <= '0;
        end else if (wr_en && wr_addr != '0 && warp_ok(wr_warp_id)) begin
            mem[bank_of(wr_warp_id, wr_addr)][{wr_warp_id, wr_addr[AW-1:BB]}] <= wr_data;
        end
    end

    // Read FSM with registered valids, data, busy and sticky err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            busy                <= 1'b0;
            oprand_1_data_valid <= 1'b0;
            oprand_2_data_valid <= 1'b0;
            oprand_1_data       <= '0;
            oprand_2_data       <= '0;
            err                 <= 1'b0;
            p2_warp             <= '0;
            p2_addr             <= '0;
        end else begin
            oprand_1_data_valid <= 1'b0;
            oprand_2_data_valid <= 1'b0;
            busy                <= 1'b0;
            if (wr_en && !warp_ok(wr_warp_id))
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if ((oprand_1_request || oprand_2_request) && !warp_ok(reg_file_read_warp_id))
                        err <= 1'b1;
                    if (oprand_1_request) begin
                        oprand_1_data_valid <= 1'b1;
                        oprand_1_data       <= rd(reg_file_read_warp_id, oprand_1_addr);
                    end
                    if (oprand_2_request) begin
                        if (oprand_1_request && oprand_1_addr != oprand_2_addr &&
                            bank_of(reg_file_read_warp_id, oprand_1_addr) ==
                            bank_of(reg_file_read_warp_id, oprand_2_addr)) begin
                            // Bank conflict: defer port 2 by one cycle.
                            p2_warp <= reg_file_read_warp_id;
                            p2_addr <= oprand_2_addr;
                            state   <= SECOND;
                            busy    <= 1'b1;
                        end else begin
                            oprand_2_data_valid <= 1'b1;
                            oprand_2_data       <= rd(reg_file_read_warp_id, oprand_2_addr);
                        end
                    end
                end
                SECOND: begin
                    // New requests here are dropped; the requester re-presents them.
                    oprand_2_data_valid <= 1'b1;
                    oprand_2_data       <= rd(p2_warp, p2_addr);
                    state               <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
